spm_banked_arb: RTL and testbench
=================================

Name: spm_banked_arb

Overview:
Parametrised successor to the scratchpad memory: a word-addressed SPM shared by the IF (instruction fetch) and MEM (load/store) stages, split into NUM_BANKS single-port banks interleaved on the low address bits. Requests to different banks are served in the same cycle. Requests to the same bank are arbitrated: MEM has priority, and a starvation counter guarantees IF forward progress. Adds byte-enabled MEM writes, an active-low grant per port, and a registered one-cycle read return with a valid strobe.

Parameters:
DATA_W, 32, data word width; multiple of 8.
ADDR_W, 12, word-address width per port.
NUM_BANKS, 4, bank count; power of two, 1..2^(ADDR_W-1).
STARVE_LIMIT, 3, consecutive IF conflict losses before IF wins the next conflict; >=1.

Ports:
clk  in  1  clock; all state on rising edge.
reset_  in  1  asynchronous active-low reset.
if_spm_addr  in  ADDR_W  IF word address.
if_spm_as_  in  1  IF access strobe, active-low.
if_spm_rw  in  1  IF direction: 1 = READ, 0 = WRITE.
if_spm_wr_data  in  DATA_W  IF write data; always a full-word write.
if_spm_rdy_  out  1  IF grant, active-low, combinational; request accepted on this edge.
if_spm_rd_data  out  DATA_W  IF read data, registered.
if_spm_rvalid  out  1  IF read data valid, one-cycle pulse.
mem_spm_addr  in  ADDR_W  MEM word address.
mem_spm_as_  in  1  MEM access strobe, active-low.
mem_spm_rw  in  1  MEM direction: 1 = READ, 0 = WRITE.
mem_spm_wr_data  in  DATA_W  MEM write data.
mem_spm_be  in  DATA_W/8  MEM byte enables, active-high; bit i gates byte i.
mem_spm_rdy_  out  1  MEM grant, active-low, combinational.
mem_spm_rd_data  out  DATA_W  MEM read data, registered.
mem_spm_rvalid  out  1  MEM read data valid, one-cycle pulse.

Behaviour:
- Address split: BANK_W = log2(NUM_BANKS). Bank = addr[BANK_W-1:0]; row = addr[ADDR_W-1:BANK_W]. With NUM_BANKS=1, BANK_W=0, so every dual request conflicts.
- Each bank is a reg array, DATA_W x 2^(ADDR_W-BANK_W), with one access per cycle. Contents are not reset.
- Conflict = both as_ low and the bank fields are equal. This includes the identical-address case.
- Grant, combinational:
  - No conflict: each port's rdy_ = its as_.
  - Conflict, starve_cnt < STARVE_LIMIT: mem_spm_rdy_=0, if_spm_rdy_=1.
  - Conflict, starve_cnt == STARVE_LIMIT: if_spm_rdy_=0, mem_spm_rdy_=1.
- A port with as_ high always sees rdy_=1. A denied requester must hold addr, rw and data stable until granted. The block stores no pending request.
- starve_cnt (width holds STARVE_LIMIT), reset 0:
  - +1 on each edge where IF is denied by conflict.
  - Cleared on any IF grant.
  - Saturates at STARVE_LIMIT.
- Write, on a granted edge with rw=0:
  - Bank row updated at that edge.
  - IF writes all bytes.
  - MEM writes only bytes with be=1; be=0 on a granted write is a legal no-op.
  - No rvalid is produced.
- Read, on a granted edge with rw=1:
  - rd_data loaded with the row contents (pre-write value, no write-through) at that edge.
  - rvalid=1 for exactly the following cycle.
  - rd_data holds its value until the next granted read.
  - Latency: request at cycle N, data and rvalid at cycle N+1.
- Back-to-back granted reads produce continuous rvalid and new data each cycle.
- Simultaneous different-bank accesses, including IF write plus MEM read, complete independently in the same cycle.
- Reset (reset_=0, asynchronous):
  - rd_data=0, rvalid=0, starve_cnt=0 on both ports.
  - rdy_ outputs forced 1 while reset_=0.
  - No bank write occurs on an edge during reset.
  - An in-flight read whose rvalid was due is dropped.
- Out-of-range addresses cannot exist, since the full ADDR_W space is mapped.

Test Plan:
1. Reset: reset_=0 mid-read -> rvalid=0, rd_data=0, both rdy_=1 immediately; after release, MEM reads 0x004 -> data at N+1 with rvalid pulse.
2. Byte enables: MEM writes 0x010=0xDEADBEEF (be=1111), then 0x010=0x00000011 (be=0001); IF reads 0x010 -> 0xDEADBE11 one cycle after grant.
3. Parallel banks: IF reads 0x001 (bank 1) while MEM writes 0x002 (bank 2) -> both rdy_=0 same cycle; IF rvalid next cycle; 0x002 updated.
4. Conflict priority: IF and MEM both read 0x008 and 0x00C (bank 0) -> MEM granted, IF rdy_=1; IF granted the next cycle once MEM deasserts as_.
5. Starvation: MEM hammers bank 3 every cycle while IF holds a read to bank 3, STARVE_LIMIT=3 -> IF denied 3 cycles, granted on the 4th (MEM rdy_=1 that cycle), then MEM priority resumes.
6. Same-address read/write collision: MEM writes 0x020=0x5 while IF reads 0x020 -> MEM wins; IF granted next cycle and returns 0x5. With NUM_BANKS=1, any dual request -> exactly one grant.

Source files
------------

// File: rtl/spm_banked_arb_if.sv
// Request/response bundle for the banked scratchpad: one IF port and one MEM port.
// Signal names match the scratchpad port list; the DUT attaches through the slave modport.
interface spm_banked_arb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] if_spm_addr;
  logic              if_spm_as_;
  logic              if_spm_rw;
  logic [DATA_W-1:0] if_spm_wr_data;
  logic              if_spm_rdy_;
  logic [DATA_W-1:0] if_spm_rd_data;
  logic              if_spm_rvalid;

  logic [ADDR_W-1:0] mem_spm_addr;
  logic              mem_spm_as_;
  logic              mem_spm_rw;
  logic [DATA_W-1:0] mem_spm_wr_data;
  logic [BE_W-1:0]   mem_spm_be;
  logic              mem_spm_rdy_;
  logic [DATA_W-1:0] mem_spm_rd_data;
  logic              mem_spm_rvalid;

  modport master (
    output if_spm_addr, if_spm_as_, if_spm_rw, if_spm_wr_data,
    input  if_spm_rdy_, if_spm_rd_data, if_spm_rvalid,
    output mem_spm_addr, mem_spm_as_, mem_spm_rw, mem_spm_wr_data, mem_spm_be,
    input  mem_spm_rdy_, mem_spm_rd_data, mem_spm_rvalid
  );

  modport slave (
    input  if_spm_addr, if_spm_as_, if_spm_rw, if_spm_wr_data,
    output if_spm_rdy_, if_spm_rd_data, if_spm_rvalid,
    input  mem_spm_addr, mem_spm_as_, mem_spm_rw, mem_spm_wr_data, mem_spm_be,
    output mem_spm_rdy_, mem_spm_rd_data, mem_spm_rvalid
  );
endinterface

// File: rtl/spm_banked_arb.sv
// Banked scratchpad shared by IF and MEM: low address bits select a single-port bank,
// same-bank conflicts go to MEM unless IF has lost STARVE_LIMIT conflicts in a row.
module spm_banked_arb #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic             clk,
  input logic             reset_,
  spm_banked_arb_if.slave bus
);
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned BANK_W   = $clog2(NUM_BANKS);
  localparam int unsigned SEL_W    = (BANK_W == 0) ? 1 : BANK_W;
  localparam int unsigned ROW_W    = ADDR_W - BANK_W;
  localparam int unsigned ROWS     = 1 << ROW_W;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [ADDR_W-1:0]   BANK_MASK  = ADDR_W'(NUM_BANKS - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [SEL_W-1:0]    if_bank, mem_bank;
  logic [ROW_W-1:0]    if_row, mem_row;
  logic                if_req, mem_req, conflict, starved, if_gnt, mem_gnt;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   bank_rdata [NUM_BANKS];

  logic [DATA_W-1:0]   if_rd_data_q, if_rd_data_d, mem_rd_data_q, mem_rd_data_d;
  logic                if_rvalid_q, if_rvalid_d, mem_rvalid_q, mem_rvalid_d;

  // Address split; with a single bank the bank field is constant zero so every pair conflicts
  always_comb begin
    if_bank  = SEL_W'(bus.if_spm_addr & BANK_MASK);
    mem_bank = SEL_W'(bus.mem_spm_addr & BANK_MASK);
    if_row   = ROW_W'(bus.if_spm_addr >> BANK_W);
    mem_row  = ROW_W'(bus.mem_spm_addr >> BANK_W);
  end

  // Arbitration and starvation tracking; requests are ignored while reset is asserted
  always_comb begin
    if_req   = reset_ & ~bus.if_spm_as_;
    mem_req  = reset_ & ~bus.mem_spm_as_;
    conflict = if_req & mem_req & (if_bank == mem_bank);
    starved  = (starve_q == STARVE_MAX);
    if_gnt   = if_req & (~conflict | starved);
    mem_gnt  = mem_req & (~conflict | ~starved);

    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (conflict && !starved) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  assign bus.if_spm_rdy_  = ~if_gnt;
  assign bus.mem_spm_rdy_ = ~mem_gnt;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] bank_q [ROWS];
    logic              sel_if, sel_mem, we;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   wbe;

    // Arbitration guarantees at most one granted port per bank each cycle
    always_comb begin
      sel_if  = if_gnt & (if_bank == SEL_W'(b));
      sel_mem = mem_gnt & (mem_bank == SEL_W'(b));
      row     = sel_mem ? mem_row : if_row;
      wdata   = sel_mem ? bus.mem_spm_wr_data : bus.if_spm_wr_data;
      wbe     = sel_mem ? bus.mem_spm_be : '1;
      we      = (sel_mem & ~bus.mem_spm_rw) | (sel_if & ~bus.if_spm_rw);
    end

    always_ff @(posedge clk) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (wbe[i]) bank_q[row][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end

    assign bank_rdata[b] = bank_q[row];
  end

  // Read return: capture pre-write row contents, hold until the next granted read
  always_comb begin
    if_rvalid_d   = if_gnt & bus.if_spm_rw;
    mem_rvalid_d  = mem_gnt & bus.mem_spm_rw;
    if_rd_data_d  = if_rvalid_d ? bank_rdata[if_bank] : if_rd_data_q;
    mem_rd_data_d = mem_rvalid_d ? bank_rdata[mem_bank] : mem_rd_data_q;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      starve_q      <= '0;
      if_rd_data_q  <= '0;
      if_rvalid_q   <= 1'b0;
      mem_rd_data_q <= '0;
      mem_rvalid_q  <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      if_rd_data_q  <= if_rd_data_d;
      if_rvalid_q   <= if_rvalid_d;
      mem_rd_data_q <= mem_rd_data_d;
      mem_rvalid_q  <= mem_rvalid_d;
    end
  end

  assign bus.if_spm_rd_data  = if_rd_data_q;
  assign bus.if_spm_rvalid   = if_rvalid_q;
  assign bus.mem_spm_rd_data = mem_rd_data_q;
  assign bus.mem_spm_rvalid  = mem_rvalid_q;
endmodule

// File: tb/tb_spm_banked_arb.sv
// Directed and random bench for spm_banked_arb against a flat-memory reference model.
module tb_spm_banked_arb;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned NUM_BANKS    = 4;
  localparam int unsigned STARVE_LIMIT = 3;
  localparam int unsigned WIN          = 64;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  spm_banked_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  spm_banked_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset_(reset_),
    .bus(bus)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  string phase   = "init";

  // Reference model: word memory indexed by full address, plus expected return registers
  logic [31:0] ref_mem [WIN];
  int          starve = 0;
  logic [31:0] exp_if_rd = '0, exp_mem_rd = '0;
  logic        exp_if_rv = 1'b0, exp_mem_rv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic chk_returns();
    chk("if_rvalid",  64'(bus.if_spm_rvalid),    64'(exp_if_rv));
    chk("if_rdata",   64'(bus.if_spm_rd_data),   64'(exp_if_rd));
    chk("mem_rvalid", 64'(bus.mem_spm_rvalid),   64'(exp_mem_rv));
    chk("mem_rdata",  64'(bus.mem_spm_rd_data),  64'(exp_mem_rd));
  endtask

  // One clock: entered just after a falling edge, leaves just after the next falling edge
  task automatic step(input logic i_as, input logic [11:0] i_a, input logic i_rw, input logic [31:0] i_d,
                      input logic m_as, input logic [11:0] m_a, input logic m_rw, input logic [31:0] m_d,
                      input logic [3:0] m_be, output bit ig, output bit mg);
    bit conf;
    bus.if_spm_as_ = i_as;  bus.if_spm_addr = i_a;  bus.if_spm_rw = i_rw;  bus.if_spm_wr_data = i_d;
    bus.mem_spm_as_ = m_as; bus.mem_spm_addr = m_a; bus.mem_spm_rw = m_rw; bus.mem_spm_wr_data = m_d;
    bus.mem_spm_be = m_be;
    #1;
    conf = !i_as && !m_as && ((int'(i_a) % NUM_BANKS) == (int'(m_a) % NUM_BANKS));
    ig = !i_as && (!conf || starve == STARVE_LIMIT);
    mg = !m_as && (!conf || starve != STARVE_LIMIT);
    chk("if_rdy_",  64'(bus.if_spm_rdy_),  64'(!ig));
    chk("mem_rdy_", 64'(bus.mem_spm_rdy_), 64'(!mg));
    @(posedge clk);
    exp_if_rv  = ig && i_rw;
    exp_mem_rv = mg && m_rw;
    if (exp_if_rv)  exp_if_rd  = ref_mem[i_a % WIN];
    if (exp_mem_rv) exp_mem_rd = ref_mem[m_a % WIN];
    if (ig && !i_rw) ref_mem[i_a % WIN] = i_d;
    if (mg && !m_rw) begin
      for (int b = 0; b < 4; b++) if (m_be[b]) ref_mem[m_a % WIN][b*8 +: 8] = m_d[b*8 +: 8];
    end
    if (ig) starve = 0;
    else if (conf && starve < STARVE_LIMIT) starve++;
    @(negedge clk);
    chk_returns();
  endtask

  task automatic idle();
    bit ig, mg;
    step(1'b1, '0, 1'b1, '0, 1'b1, '0, 1'b1, '0, '0, ig, mg);
  endtask

  initial begin
    bit ig, mg;
    logic        i_as, m_as, i_rw, m_rw;
    logic [11:0] i_a, m_a;
    logic [31:0] i_d, m_d;
    logic [3:0]  m_be;

    // Reset with both strobes low: grants suppressed, returns cleared
    bus.if_spm_as_ = 1'b0;  bus.if_spm_addr = '0;  bus.if_spm_rw = 1'b1;  bus.if_spm_wr_data = '0;
    bus.mem_spm_as_ = 1'b0; bus.mem_spm_addr = 12'h001; bus.mem_spm_rw = 1'b0; bus.mem_spm_wr_data = '0;
    bus.mem_spm_be = '1;
    #1;
    phase = "reset0";
    chk("if_rdy_",  64'(bus.if_spm_rdy_),  64'd1);
    chk("mem_rdy_", 64'(bus.mem_spm_rdy_), 64'd1);
    chk_returns();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;

    phase = "preload";
    for (int a = 0; a < WIN; a++) begin
      step(1'b1, '0, 1'b1, '0, 1'b0, 12'(a), 1'b0, 32'(a) * 32'h0101_0101 ^ 32'hA500_0000, 4'hF, ig, mg);
    end

    // Reset asserted mid-read drops the pending rvalid and blocks writes
    phase = "reset_mid";
    bus.mem_spm_as_ = 1'b0; bus.mem_spm_addr = 12'h010; bus.mem_spm_rw = 1'b1;
    @(posedge clk);
    #2;
    chk("rv_before", 64'(bus.mem_spm_rvalid), 64'd1);
    chk("rd_before", 64'(bus.mem_spm_rd_data), 64'(ref_mem[16]));
    reset_ = 1'b0;
    #1;
    exp_if_rv = 1'b0; exp_mem_rv = 1'b0; exp_if_rd = '0; exp_mem_rd = '0; starve = 0;
    chk_returns();
    bus.if_spm_as_ = 1'b0; bus.if_spm_addr = 12'h005; bus.if_spm_rw = 1'b1;
    bus.mem_spm_addr = 12'h004; bus.mem_spm_rw = 1'b0; bus.mem_spm_wr_data = 32'hFFFF_FFFF;
    #1;
    chk("if_rdy_",  64'(bus.if_spm_rdy_),  64'd1);
    chk("mem_rdy_", 64'(bus.mem_spm_rdy_), 64'd1);
    @(posedge clk);
    #1;
    chk_returns();
    @(negedge clk);
    reset_ = 1'b1;
    phase = "post_reset";
    step(1'b1, '0, 1'b1, '0, 1'b0, 12'h004, 1'b1, '0, 4'hF, ig, mg);
    chk("read4", 64'(bus.mem_spm_rd_data), 64'(32'h0404_0404 ^ 32'hA500_0000));

    phase = "byte_en";
    step(1'b1, '0, 1'b1, '0, 1'b0, 12'h010, 1'b0, 32'hDEAD_BEEF, 4'hF, ig, mg);
    step(1'b1, '0, 1'b1, '0, 1'b0, 12'h010, 1'b0, 32'h0000_0011, 4'h1, ig, mg);
    step(1'b0, 12'h010, 1'b1, '0, 1'b1, '0, 1'b1, '0, 4'h0, ig, mg);
    chk("merged", 64'(bus.if_spm_rd_data), 64'h0000_0000_DEAD_BE11);
    step(1'b1, '0, 1'b1, '0, 1'b0, 12'h010, 1'b0, 32'h1234_5678, 4'h0, ig, mg);
    step(1'b1, '0, 1'b1, '0, 1'b0, 12'h010, 1'b1, '0, 4'h0, ig, mg);

    phase = "parallel";
    step(1'b0, 12'h001, 1'b1, '0, 1'b0, 12'h002, 1'b0, 32'hCAFE_F00D, 4'hF, ig, mg);
    step(1'b1, '0, 1'b1, '0, 1'b0, 12'h002, 1'b1, '0, 4'h0, ig, mg);
    chk("wr2", 64'(bus.mem_spm_rd_data), 64'h0000_0000_CAFE_F00D);

    phase = "conflict";
    step(1'b0, 12'h008, 1'b1, '0, 1'b0, 12'h00C, 1'b1, '0, 4'h0, ig, mg);
    step(1'b0, 12'h008, 1'b1, '0, 1'b1, '0, 1'b1, '0, 4'h0, ig, mg);

    phase = "starve";
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 12'h003, 1'b1, '0, 1'b0, 12'(7 + 4 * (k % 2)), 1'b1, '0, 4'h0, ig, mg);
    end

    phase = "same_addr";
    step(1'b0, 12'h020, 1'b1, '0, 1'b0, 12'h020, 1'b0, 32'h5, 4'hF, ig, mg);
    step(1'b0, 12'h020, 1'b1, '0, 1'b1, '0, 1'b1, '0, 4'h0, ig, mg);
    chk("rd20", 64'(bus.if_spm_rd_data), 64'h5);
    idle();

    // Random traffic; a denied requester holds its request until granted
    phase = "random";
    ig = 1'b1; mg = 1'b1; i_as = 1'b1; m_as = 1'b1;
    i_a = '0; m_a = '0; i_rw = 1'b1; m_rw = 1'b1; i_d = '0; m_d = '0; m_be = '0;
    for (int k = 0; k < 400; k++) begin
      if (i_as || ig) begin
        i_as = ($urandom_range(0, 3) == 0);
        i_a  = 12'($urandom_range(0, WIN - 1));
        i_rw = 1'($urandom);
        i_d  = $urandom;
      end
      if (m_as || mg) begin
        m_as = ($urandom_range(0, 3) == 0);
        m_a  = 12'($urandom_range(0, WIN - 1));
        m_rw = 1'($urandom);
        m_d  = $urandom;
        m_be = 4'($urandom);
      end
      step(i_as, i_a, i_rw, i_d, m_as, m_a, m_rw, m_d, m_be, ig, mg);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
